ps2_host_cmd: RTL
=================

# ps2_host_cmd

Host-to-device command path for the PS/2 monitor design: consumes ASCII hex characters from the UART receiver FIFO, assembles each pair into one command byte, hands it to the PS/2 transmitter, and waits for transmit completion or timeout. It sits between the `uart` receive side (`rd_uart`/`r_data`/`rx_empty`) and the `ps2_rxtx` write side (`wr_ps2`/`din`/`tx_done_tick`), letting a terminal send commands such as `ED` or `FF` to the keyboard.

## Interface
- `TIMEOUT_CYCLES`, 2_500_000: clock cycles allowed between the PS/2 write pulse and `tx_done_tick`; 50 ms at 50 MHz.
- `TW`, 22: timeout counter width; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_empty`  in  1  UART RX FIFO empty flag.
- `r_data`  in  8  UART RX FIFO head; valid whenever `rx_empty`=0.
- `rd_uart`  out  1  FIFO pop; `r_data` is consumed in the same cycle.
- `wr_ps2`  out  1  one-cycle start pulse to the PS/2 transmitter.
- `ps2_din`  out  8  command byte, registered.
- `tx_done_tick`  in  1  PS/2 transmitter completion pulse.
- `busy`  out  1  high while a PS/2 transaction is outstanding.
- `err_tick`  out  1  one-cycle pulse on a bad character or a timeout.
- `cmd_cnt`  out  8  count of successful commands; wraps 255→0.
- `tx_full`  in  1  UART TX FIFO full; used only with echo enabled.
- `wr_uart`  out  1  UART TX write pulse.
- `w_data`  out  8  UART TX byte.

## Operation
- States:
  - HI: wait for the high nibble.
  - LO: wait for the low nibble.
  - SEND: issue the PS/2 write.
  - WAIT: wait for completion or timeout.
  - RPT: echo the result; present only with echo enabled.
- Character decode: `0`–`9`→0–9; `A`–`F` and `a`–`f`→10–15. Whitespace is 0x20, 0x0D and 0x0A. Any other value is invalid.
- `rd_uart` = (state is HI or LO) && !`rx_empty`. It is combinational, so exactly one character is popped per such cycle.
- HI behaviour:
  - Hex character: store it in `ps2_din[7:4]`, go to LO.
  - Whitespace: drop it, stay in HI.
  - Invalid character: pulse `err_tick`, set the result to error, go to RPT if echo is enabled, otherwise stay in HI.
- LO behaviour:
  - Hex character: store it in `ps2_din[3:0]`, go to SEND.
  - Whitespace or invalid character: pulse `err_tick`, discard the high nibble, set the result to error, then go to RPT or HI.
- SEND: `wr_ps2`=1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - `tx_done_tick` arrives: increment `cmd_cnt`, set the result to OK, go to RPT or HI.
  - Counter reaches TIMEOUT_CYCLES−1 with no done: pulse `err_tick`, set the result to error, go to RPT or HI.
  - `tx_done_tick` in the same cycle as the terminal count: success wins.
  - `tx_done_tick` seen outside WAIT is ignored.
- `busy` = (state is SEND or WAIT).
- `ps2_din` holds its value from SEND until the next nibble is written.
- No characters are popped in SEND, WAIT or RPT; they stay buffered in the FIFO.
- Reset values: state HI, `ps2_din`=0x00, `cmd_cnt`=0x00, counter 0. All pulse outputs are 0, `busy`=0, `w_data`=0x00.
- Reset mid-transaction returns the block to HI without aborting the transaction already started in the PS/2 transmitter. A late `tx_done_tick` after reset is ignored.

## Timing
- Character to `rd_uart`: same cycle as `rx_empty` goes low while in HI or LO.
- Second hex character popped in cycle N → `wr_ps2` in cycle N+1 → WAIT from N+2.
- `tx_done_tick` in cycle M → `cmd_cnt` updated at M+1. Ready for the next character at M+1 without echo, or after the RPT write with echo.
- Timeout: `err_tick` fires TIMEOUT_CYCLES cycles after the WAIT entry edge.
- `err_tick` is registered and aligned with the state transition it reports.

## Configuration
- `PS2_HOST_CMD_ECHO_EN` defined:
  - RPT state exists and holds while `tx_full`=1.
  - When `tx_full`=0 it writes one byte: `wr_uart`=1 for one cycle, `w_data`=0x4B (`K`) on success or 0x3F (`?`) on error, then goes to HI.
- Undefined:
  - RPT is not built; success and error paths go directly to HI.
  - `wr_uart` is tied to 0 and `w_data` to 0x00; `tx_full` is unused.

## Test plan
- Feed FIFO `E`,`D`, then pulse `tx_done_tick` 100 cycles after `wr_ps2` → exactly one `wr_ps2` with `ps2_din`=0xED, `cmd_cnt`=1, `busy` high for 101 cycles, no `err_tick`.
- Feed `f`,`F`,` `,`0`,`5` → commands 0xFF then 0x05 in order. The space between the commands is ignored. No character is popped while `busy`=1.
- Feed `G`, then `A`,`\r` → two `err_tick` pulses, no `wr_ps2`. With echo: `w_data` 0x3F written twice.
- Feed `F`,`4` with no `tx_done_tick`, TIMEOUT_CYCLES=100 → `err_tick` 100 cycles after WAIT entry, `cmd_cnt` unchanged, next character accepted.
- With echo, `tx_full`=1 on success → block stays in RPT with `wr_uart`=0. Release → single 0x4B write, return to HI.
- Assert `reset` during WAIT, then pulse `tx_done_tick` → all outputs at reset values, `cmd_cnt` stays 0, next `0`,`0` pair sends 0x00.

Source files
------------

// File: rtl/ps2_host_cmd_if.sv
// Bundles the UART receive/transmit and PS/2 write-side signals of ps2_host_cmd.
// The master modport is the command block's view; slave is the surrounding system's view.
interface ps2_host_cmd_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       wr_ps2;
    logic [7:0] ps2_din;
    logic       tx_done_tick;
    logic       busy;
    logic       err_tick;
    logic [7:0] cmd_cnt;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;

    modport master (
        input  rx_empty, r_data, tx_done_tick, tx_full,
        output rd_uart, wr_ps2, ps2_din, busy, err_tick, cmd_cnt, wr_uart, w_data
    );

    modport slave (
        output rx_empty, r_data, tx_done_tick, tx_full,
        input  rd_uart, wr_ps2, ps2_din, busy, err_tick, cmd_cnt, wr_uart, w_data
    );
endinterface

// File: rtl/ps2_host_cmd.sv
// Assembles ASCII hex pairs from the UART RX FIFO into PS/2 command bytes and tracks completion.
// Define PS2_HOST_CMD_ECHO_EN to echo 'K'/'?' results back through the UART transmitter.
module ps2_host_cmd #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int TW             = 22
) (
    input  logic           clk,
    input  logic           reset,
    ps2_host_cmd_if.master bus
);

    typedef enum logic [2:0] {
        ST_HI,
        ST_LO,
        ST_SEND,
`ifdef PS2_HOST_CMD_ECHO_EN
        ST_WAIT,
        ST_RPT
`else
        ST_WAIT
`endif
    } state_t;

    // Every finished command (good or bad) funnels through the result report when echo exists.
`ifdef PS2_HOST_CMD_ECHO_EN
    localparam state_t RESULT_ST = ST_RPT;
`else
    localparam state_t RESULT_ST = ST_HI;
`endif

    localparam logic [TW-1:0] TERM_CNT = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    din_q;
    logic [7:0]    cmd_cnt_q;
    logic          wr_ps2_q;
    logic          busy_q;
    logic          err_q;

    logic          pop;
    logic          hex_valid;
    logic [3:0]    hex_nib;
    logic          is_ws;
    logic          succ_evt;
    logic          tmo_evt;
    logic          char_err;
    logic          err_evt;

    assign pop          = ((state == ST_HI) || (state == ST_LO)) && !bus.rx_empty;
    assign bus.rd_uart  = pop;
    assign bus.wr_ps2   = wr_ps2_q;
    assign bus.ps2_din  = din_q;
    assign bus.busy     = busy_q;
    assign bus.err_tick = err_q;
    assign bus.cmd_cnt  = cmd_cnt_q;

    // Letters share low nibbles 1..6 in both cases, so +9 maps them onto 10..15.
    always_comb begin
        hex_valid = 1'b0;
        hex_nib   = 4'h0;
        is_ws     = 1'b0;
        if (bus.r_data >= 8'h30 && bus.r_data <= 8'h39) begin
            hex_valid = 1'b1;
            hex_nib   = bus.r_data[3:0];
        end else if ((bus.r_data >= 8'h41 && bus.r_data <= 8'h46) ||
                     (bus.r_data >= 8'h61 && bus.r_data <= 8'h66)) begin
            hex_valid = 1'b1;
            hex_nib   = bus.r_data[3:0] + 4'd9;
        end else if (bus.r_data == 8'h20 || bus.r_data == 8'h0D || bus.r_data == 8'h0A) begin
            is_ws = 1'b1;
        end
    end

    always_comb begin
        succ_evt = (state == ST_WAIT) && bus.tx_done_tick;
        tmo_evt  = (state == ST_WAIT) && !bus.tx_done_tick && (tmo_cnt == TERM_CNT);
        char_err = pop && !hex_valid && ((state == ST_LO) || !is_ws);
        err_evt  = char_err || tmo_evt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_HI;
            tmo_cnt   <= '0;
            din_q     <= 8'h00;
            cmd_cnt_q <= 8'h00;
            wr_ps2_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_ps2_q <= 1'b0;
            err_q    <= err_evt;
            case (state)
                ST_HI: begin
                    if (pop) begin
                        if (hex_valid) begin
                            din_q[7:4] <= hex_nib;
                            state      <= ST_LO;
                        end else if (!is_ws) begin
                            state <= RESULT_ST;
                        end
                    end
                end
                ST_LO: begin
                    if (pop) begin
                        if (hex_valid) begin
                            din_q[3:0] <= hex_nib;
                            wr_ps2_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            state      <= ST_SEND;
                        end else begin
                            state <= RESULT_ST;
                        end
                    end
                end
                ST_SEND: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                // Completion beats a simultaneous terminal count.
                ST_WAIT: begin
                    if (bus.tx_done_tick) begin
                        cmd_cnt_q <= cmd_cnt_q + 8'd1;
                        busy_q    <= 1'b0;
                        state     <= RESULT_ST;
                    end else if (tmo_cnt == TERM_CNT) begin
                        busy_q <= 1'b0;
                        state  <= RESULT_ST;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
`ifdef PS2_HOST_CMD_ECHO_EN
                ST_RPT: begin
                    if (!bus.tx_full) begin
                        state <= ST_HI;
                    end
                end
`endif
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_HI;
                end
            endcase
        end
    end

`ifdef PS2_HOST_CMD_ECHO_EN
    logic       ok_q;
    logic       wr_uart_q;
    logic [7:0] w_data_q;

    assign bus.wr_uart = wr_uart_q;
    assign bus.w_data  = w_data_q;

    // The result flag is latched on the event that sends the FSM to RPT and read on leaving it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ok_q      <= 1'b0;
            wr_uart_q <= 1'b0;
            w_data_q  <= 8'h00;
        end else begin
            wr_uart_q <= 1'b0;
            if (succ_evt) begin
                ok_q <= 1'b1;
            end else if (err_evt) begin
                ok_q <= 1'b0;
            end
            if (state == ST_RPT && !bus.tx_full) begin
                wr_uart_q <= 1'b1;
                w_data_q  <= ok_q ? 8'h4B : 8'h3F;
            end
        end
    end
`else
    logic unused_tx_full;
    logic unused_succ_evt;

    assign unused_tx_full  = bus.tx_full;
    assign unused_succ_evt = succ_evt;
    assign bus.wr_uart     = 1'b0;
    assign bus.w_data      = 8'h00;
`endif

endmodule
